// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous input over a window
// of GATE_CYCLES system clocks and presents the count with a one-cycle strobe.
module clk_freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned GATE_W      = 27,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sig_in_i,
    input  logic             start_i,
    input  logic             continuous_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             overflow_o,
    output logic             stalled_o
);
    // state   | meaning
    // IDLE    | waiting for start or continuous
    // MEASURE | window open, gate and edge counters running
    // DONE    | result cycle, count_valid high, edges discarded
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic s1_q, s2_q, prev_q;
    logic edge_det;

    // Input path resets high so a signal already high at reset is not an edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= sig_in_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~prev_q;

    logic [1:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edges_q, edges_d, edges_inc;
    logic              ovf_pend_q, ovf_pend_d, ovf_inc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              stalled_q, stalled_d;
    logic              go;

    assign go = start_i | continuous_i;

    always_comb begin
        edges_inc = edges_q;
        ovf_inc   = ovf_pend_q;
        if (edge_det) begin
            if (edges_q == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                edges_inc = edges_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edges_d    = edges_q;
        ovf_pend_d = ovf_pend_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stalled_d  = stalled_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d    = ST_MEASURE;
                    gate_d     = '0;
                    edges_d    = '0;
                    ovf_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                edges_d    = edges_inc;
                ovf_pend_d = ovf_inc;
                // An edge in the last window cycle still lands in the result.
                if (gate_q == GATE_LAST) begin
                    state_d    = ST_DONE;
                    count_d    = edges_inc;
                    overflow_d = ovf_inc;
                    stalled_d  = (edges_inc == '0);
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            edges_q    <= '0;
            ovf_pend_q <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edges_q    <= edges_d;
            ovf_pend_q <= ovf_pend_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stalled_q  <= stalled_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign count_valid_o = (state_q == ST_DONE);
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign stalled_o     = stalled_q;
endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Gated edge counter that measures the frequency of a slow, asynchronous clock-like signal (camera PCLK/VSYNC, divided test clocks) in the system clock domain. It synchronizes `sig_in`, counts its rising edges over a fixed window of `GATE_CYCLES` system clocks, and presents the result with a one-cycle valid strobe. It is the receive-side check for the design's clock dividers. With the 100 MHz board clock and the default window, the result reads directly in Hz.

## Interface
- `GATE_CYCLES`, default 100_000_000: window length in `clk` cycles (1 s at 100 MHz); must be ≥ 4.
- `GATE_W`, default 27: width of the window counter; must satisfy 2^GATE_W > GATE_CYCLES.
- `CNT_W`, default 32: width of the edge counter and of `count`.

Ports:
- `clk` in 1: system clock; all logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sig_in` in 1: asynchronous signal to measure.
- `start` in 1: level; sampled in IDLE and DONE, requests one measurement.
- `continuous` in 1: level; when high, windows repeat automatically.
- `busy` out 1: high in MEASURE and DONE.
- `count` out CNT_W: rising-edge count of the last completed window; held until the next DONE.
- `count_valid` out 1: high for exactly the one DONE cycle.
- `overflow` out 1: the edge counter saturated in the last window; held with `count`.
- `stalled` out 1: the last window saw zero edges; held with `count`.

## Operation
- **Input path:** two-flop synchronizer `s1`→`s2`, then a `prev` register. A detected edge is `s2 & ~prev`.
- **Reset values for the input path:** `s1`, `s2` and `prev` reset to 1. A `sig_in` that is high at or out of reset produces no spurious edge.
- **FSM states:** IDLE, MEASURE, DONE. Reset state is IDLE.
- **IDLE:**
  - `busy`=0.
  - If `start|continuous`: clear the gate counter and edge counter, then go to MEASURE.
- **MEASURE:**
  - The gate counter increments each cycle.
  - The edge counter increments on each detected edge and saturates at 2^CNT_W−1.
  - The overflow-pending bit is set if an edge arrives while the counter is saturated.
  - In the cycle where the gate counter equals GATE_CYCLES−1, an edge in that cycle is still counted. On the next clock, load `count` and `overflow`, set `stalled` = (final count == 0), and go to DONE.
  - MEASURE therefore lasts exactly GATE_CYCLES cycles.
- **DONE:** one cycle.
  - `count_valid`=1.
  - Edges detected in DONE are discarded (dead cycle).
  - Next state is MEASURE (counters cleared) if `start|continuous`, else IDLE.
- **start while busy:** `start` in MEASURE is ignored; no restart and no extension of the window.
- **Deasserting continuous:** deasserting `continuous` in MEASURE lets the current window complete normally.

## Timing
- **Output reset values:** on `reset`, `count`=0, `count_valid`=0, `overflow`=0, `stalled`=0 and `busy`=0, asynchronously; the counters clear too.
- **Reset mid-window:** discards the partial measurement; no `count_valid` is issued.
- **Input latency:** a `sig_in` rising edge first sampled at clk edge k is counted at clk edge k+2; the edge is visible to the counter in the cycle after k+1.
- **Minimum pulse:** `sig_in` must be stable high ≥ 2 clk and low ≥ 2 clk per period to be counted reliably. Faster input is out of spec.
- **Start to result:** from `start` sampled high in IDLE, `count_valid` rises GATE_CYCLES+1 clocks later.
- **Continuous period:** in continuous mode `count_valid` recurs every GATE_CYCLES+1 clocks.
- **Window arithmetic:** the gate counter never exceeds GATE_CYCLES−1. The edge counter must not wrap (saturate only).
- **Output stability:** `count`, `overflow` and `stalled` change only on the clock that enters DONE.

## Test plan
1. GATE_CYCLES=100, `sig_in` period 10 clk, first rising edge ≥ 3 clk after `start`, exactly 10 rising edges inside the window → `count_valid` one cycle at start+101, `count`=10, `stalled`=0, `overflow`=0.
2. `sig_in` held high through and after reset, `start` pulsed → `count`=0, `stalled`=1 (no spurious edge from the synchronizer reset).
3. CNT_W=4, GATE_CYCLES=200, 20 edges in the window → `count`=15, `overflow`=1. The next window with 3 edges → `count`=3, `overflow`=0.
4. `continuous`=1 for 3 windows with `start` toggled mid-window → `count_valid` at exactly 101-cycle spacing, window length unchanged. Drop `continuous` mid-window → the window completes, then IDLE with `busy`=0.
5. `reset` asserted at cycle 50 of a window → all outputs 0 asynchronously, no `count_valid`. A new `start` then yields the correct count for its own edges only.
6. `sig_in` edge arranged to reach the detector in the DONE cycle (continuous mode) → not counted in either adjacent window. An edge in the final MEASURE cycle → counted.
